serial_adder_host: RTL and testbench

SERIAL_ADDER_HOST -- requirements
Module: serial_adder_host

---
 rtl/serial_adder_host_pkg.sv | 19 +
 rtl/serial_adder_host_if.sv | 51 +++++
 rtl/serial_adder_host.sv | 94 +++++++++
 tb/tb_serial_adder_host.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_host_pkg.sv
// Shared types and constants for the bit-serial adder host.
// The state enum and default operand width are used by the host and its interface.
package serial_adder_host_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed by a counter that must reach the value w (bit-cycles 0..w).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_host_if.sv
// Operand/result handshakes plus the serial-adder link between the host and its environment.
// The slave side is the host; the master side offers operands, runs the serial adder and takes results.
import serial_adder_host_pkg::*;

interface serial_adder_host_if #(
  parameter int W = DEFAULT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic         ser_clr;
  logic         ser_a;
  logic         ser_b;
  logic         ser_sum;

  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    output ser_clr,
    output ser_a,
    output ser_b,
    input  ser_sum,
    output out_valid,
    input  out_ready,
    output out_sum
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    input  ser_clr,
    input  ser_a,
    input  ser_b,
    output ser_sum,
    input  out_valid,
    output out_ready,
    input  out_sum
  );

endinterface

// File: rtl/serial_adder_host.sv
// Host that feeds an external bit-serial adder LSB first and reassembles the W+1 bit sum.
// One operand pair in flight at a time: IDLE -> CLEAR -> SHIFT (W+1 bits) -> DONE.
module serial_adder_host
  import serial_adder_host_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_host_if.slave   bus
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W:0]    r_sum;

  logic          w_accept;
  logic          w_last_bit;

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_last_bit = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.in_ready  = 1'b0;
    bus.ser_clr   = 1'b0;
    bus.ser_a     = 1'b0;
    bus.ser_b     = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        bus.ser_clr  = 1'b1;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        // Operands shift in zeros, so the final bit-cycle drives 0/0 and flushes the carry.
        bus.ser_a = r_a[0];
        bus.ser_b = r_b[0];
        if (w_last_bit) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else if (w_accept) begin
      r_a <= bus.in_a;
      r_b <= bus.in_b;
    end else if (r_state == SHIFT) begin
      r_a          <= r_a >> 1;
      r_b          <= r_b >> 1;
      r_sum[r_cnt] <= bus.ser_sum;
      r_cnt        <= w_last_bit ? '0 : r_cnt + CW'(1);
    end
  end

  assign bus.out_sum = r_sum;

endmodule

// File: tb/tb_serial_adder_host.sv
// Bench for serial_adder_host paired with a bit-serial adder (carry flop reset by ser_clr | rst).
// Directed corner cases, then 1000 random operand pairs checked against plain a + b.
module tb_serial_adder_host;
  import serial_adder_host_pkg::*;

  localparam int W = DEFAULT_W;

  logic clk;
  logic rst;

  serial_adder_host_if #(.W(W)) bus ();

  serial_adder_host #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The bit-serial adder the host drives: combinational sum, registered carry.
  logic r_carry;
  always_ff @(posedge clk) begin
    if (rst || bus.ser_clr) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= (bus.ser_a & bus.ser_b) | (bus.ser_a & r_carry) | (bus.ser_b & r_carry);
    end
  end
  assign bus.ser_sum = bus.ser_a ^ bus.ser_b ^ r_carry;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s a=%0h b=%0h got=%0h exp=%0h", tag, cur_a, cur_b, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge, in the CLEAR cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_wait", 32'(t < 50), 32'd1);
    cur_a        = a;
    cur_b        = b;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    check("clear_ser_clr", 32'(bus.ser_clr), 32'd1);
    check("clear_ser_ab", {30'd0, bus.ser_a, bus.ser_b}, 32'd0);
    check("clear_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic finish_op(input int hold);
    int          n;
    int          k;
    logic [W:0]  exp_sum;
    logic        exp_bit_a;
    logic        exp_bit_b;
    exp_sum = {1'b0, cur_a} + {1'b0, cur_b};
    n = 0;
    while (!bus.out_valid && n < W + 10) begin
      if (n >= 1) begin
        k = n - 1;
        exp_bit_a = (k < W) ? cur_a[k] : 1'b0;
        exp_bit_b = (k < W) ? cur_b[k] : 1'b0;
        check("shift_ser_a", 32'(bus.ser_a), 32'(exp_bit_a));
        check("shift_ser_b", 32'(bus.ser_b), 32'(exp_bit_b));
        check("shift_ser_clr", 32'(bus.ser_clr), 32'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(W + 2));
    check("sum", 32'(bus.out_sum), 32'(exp_sum));
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    check("done_ser_ab", {30'd0, bus.ser_a, bus.ser_b}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.out_sum), 32'(exp_sum));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_sum_kept", 32'(bus.out_sum), 32'(exp_sum));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    start_op(a, b);
    finish_op(hold);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    cur_a         = '0;
    cur_b         = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ser_clr", 32'(bus.ser_clr), 32'd0);
    check("rst_ser_ab", {30'd0, bus.ser_a, bus.ser_b}, 32'd0);
    check("rst_sum", 32'(bus.out_sum), 32'd0);

    // Directed: basic sum with 5 cycles of backpressure, carry-out cases, carry isolation.
    run_op(8'h5A, 8'h3C, 5);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h00, 8'h00, 0);

    // Abort mid-SHIFT while bit 3 is on the serial lines.
    start_op(8'hA7, 8'h6D);
    repeat (4) @(posedge clk);
    #1;
    check("abort_ser_a_bit3", 32'(bus.ser_a), 32'(cur_a[3]));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum", 32'(bus.out_sum), 32'd0);
    check("abort_ser_ab", {30'd0, bus.ser_a, bus.ser_b}, 32'd0);
    run_op(8'h01, 8'h02, 0);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
